// File: rtl/seq_det_pkg.sv
// Shared types and reset configuration for the programmable serial pattern detector.
// Widths here are sized for the largest legal pattern (32 bits).
package seq_det_pkg;

    localparam int PAT_W_MAX = 32;
    localparam int LEN_W_MAX = 6;

    localparam logic [PAT_W_MAX-1:0] RST_PATTERN = 32'b1011;
    localparam logic [LEN_W_MAX-1:0] RST_LEN     = 6'd4;
    localparam logic                 RST_OVERLAP = 1'b1;

    typedef struct packed {
        logic [PAT_W_MAX-1:0] pattern;
        logic [LEN_W_MAX-1:0] len;
        logic                 overlap;
    } cfg_t;

    // Ones in the low len bit positions, zeros above.
    function automatic logic [PAT_W_MAX-1:0] len_mask(input logic [LEN_W_MAX-1:0] len);
        logic [PAT_W_MAX-1:0] m;
        for (int i = 0; i < PAT_W_MAX; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc yields 1.
// One-cycle update latency, no backpressure.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= inc ? WIDTH'(1) : '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: masked compare of shift history against a loaded pattern.
// detect_out one clock after the final pattern bit; no backpressure, bits are taken whenever seq_valid.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               seq_valid,
    input  logic               seq_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               detect_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    cfg_t               r_cfg;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_detect;
    logic               r_cfg_err;

    logic                 w_cfg_ok;
    logic [MAX_LEN:0]     w_win;
    logic [PAT_W_MAX-1:0] w_win_ext;
    logic [PAT_W_MAX-1:0] w_mask;
    logic                 w_fill_ok;
    logic                 w_match;

    assign w_cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign w_win     = {r_hist, seq_in};
    assign w_win_ext = PAT_W_MAX'(w_win);
    assign w_mask    = len_mask(r_cfg.len);
    assign w_fill_ok = (LEN_W_MAX'(r_fill) + LEN_W_MAX'(1)) >= r_cfg.len;

    // A load cycle never samples data, so it can never produce a match.
    assign w_match = seq_valid && !cfg_load && w_fill_ok &&
                     (((w_win_ext ^ r_cfg.pattern) & w_mask) == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg     <= '{pattern: RST_PATTERN, len: RST_LEN, overlap: RST_OVERLAP};
            r_hist    <= '0;
            r_fill    <= '0;
            r_detect  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_detect  <= w_match;
            r_cfg_err <= cfg_load && !w_cfg_ok;
            if (cfg_load) begin
                if (w_cfg_ok) begin
                    r_cfg  <= '{pattern: PAT_W_MAX'(cfg_pattern),
                               len:     LEN_W_MAX'(cfg_len),
                               overlap: cfg_overlap};
                    r_hist <= '0;
                    r_fill <= '0;
                end
            end else if (seq_valid) begin
                r_hist <= w_win[MAX_LEN-1:0];
                // Non-overlapping mode keeps the bits but demands len fresh ones before the next hit.
                if (w_match && !r_cfg.overlap) begin
                    r_fill <= '0;
                end else if (r_fill != LEN_W'(MAX_LEN)) begin
                    r_fill <= r_fill + LEN_W'(1);
                end
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_match),
        .clr     (count_clr),
        .count   (match_count)
    );

    assign detect_out = r_detect;
    assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: directed scenarios plus random traffic against a queue-based model.
module tb_seq_detector_prog;

    localparam int ML   = 8;
    localparam int CW   = 4;
    localparam int LW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          seq_valid = 1'b0;
    logic          seq_in = 1'b0;
    logic          cfg_load = 1'b0;
    logic [ML-1:0] cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          count_clr = 1'b0;
    logic          detect_out;
    logic [CW-1:0] match_count;
    logic          cfg_err;

    int checks = 0;
    int failures = 0;

    // Reference model: received bits since the last restart, plus current configuration.
    bit            q[$];
    logic [ML-1:0] m_pat;
    int            m_len;
    bit            m_ovl;
    int            e_cnt;
    bit            e_det;
    bit            e_err;

    seq_detector_prog #(
        .MAX_LEN (ML),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seq_valid   (seq_valid),
        .seq_in      (seq_in),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .detect_out  (detect_out),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        q.delete();
        m_pat = 8'b0000_1011;
        m_len = 4;
        m_ovl = 1'b1;
        e_cnt = 0;
        e_det = 1'b0;
        e_err = 1'b0;
    endtask

    task automatic cycle(input bit v, input bit b, input bit ld, input logic [ML-1:0] pat,
                         input int len, input bit ovl, input bit clr);
        bit match;
        match       = 1'b0;
        seq_valid   = v;
        seq_in      = b;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = LW'(len);
        cfg_overlap = ovl;
        count_clr   = clr;
        e_err       = 1'b0;
        if (ld) begin
            if (len >= 1 && len <= ML) begin
                m_pat = pat;
                m_len = len;
                m_ovl = ovl;
                q.delete();
            end else begin
                e_err = 1'b1;
            end
        end else if (v) begin
            q.push_back(b);
            if (q.size() > ML) void'(q.pop_front());
            if (q.size() >= m_len) begin
                match = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (q[q.size() - 1 - i] != m_pat[i]) match = 1'b0;
                if (match && !m_ovl) q.delete();
            end
        end
        if (clr) e_cnt = match ? 1 : 0;
        else if (match && e_cnt < CMAX) e_cnt++;
        e_det = match;
        @(posedge clk);
        #1;
        seq_valid = 1'b0;
        cfg_load  = 1'b0;
        count_clr = 1'b0;
    endtask

    task automatic bit_in(input bit b);
        cycle(1'b1, b, 1'b0, '0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [ML-1:0] pat, input int len, input bit ovl);
        cycle(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (detect_out !== 1'b0) begin failures++; $display("FAIL reset_det got=%b exp=0", detect_out); end
        checks++; if (match_count !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", match_count); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    endtask

    task automatic test_default_pattern();
        bit bits[7] = '{1, 0, 1, 1, 0, 1, 1};
        for (int i = 0; i < 7; i++) begin
            bit_in(bits[i]);
            checks++;
            if (detect_out !== e_det) begin failures++; $display("FAIL dflt_det bit%0d got=%b exp=%b", i + 1, detect_out, e_det); end
        end
        checks++; if (match_count !== CW'(2)) begin failures++; $display("FAIL dflt_cnt got=%0d exp=2", match_count); end
    endtask

    task automatic test_nonoverlap();
        int base;
        load(8'b111, 3, 1'b0);
        checks++; if (cfg_err !== 1'b0 || detect_out !== 1'b0) begin failures++; $display("FAIL novl_load err=%b det=%b exp=0,0", cfg_err, detect_out); end
        base = e_cnt;
        for (int i = 0; i < 6; i++) begin
            bit_in(1'b1);
            checks++;
            if (detect_out !== e_det) begin failures++; $display("FAIL novl_det bit%0d got=%b exp=%b", i + 1, detect_out, e_det); end
        end
        checks++; if (match_count !== CW'(base + 2)) begin failures++; $display("FAIL novl_cnt got=%0d exp=%0d", match_count, base + 2); end
    endtask

    task automatic test_overlap();
        load(8'b111, 3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bit_in(1'b1);
            checks++;
            if (detect_out !== e_det) begin failures++; $display("FAIL ovl_det bit%0d got=%b exp=%b", i + 1, detect_out, e_det); end
        end
        checks++; if (match_count !== CW'(e_cnt)) begin failures++; $display("FAIL ovl_cnt got=%0d exp=%0d", match_count, e_cnt); end
    endtask

    task automatic test_gap();
        load(8'b1011, 4, 1'b1);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if (detect_out !== 1'b0) begin failures++; $display("FAIL gap_idle cyc%0d got=%b exp=0", i, detect_out); end
        end
        bit_in(1'b1);
        checks++; if (detect_out !== 1'b1 || e_det !== 1'b1) begin failures++; $display("FAIL gap_final got=%b exp=1", detect_out); end
    endtask

    task automatic test_bad_cfg();
        load(8'b1011, 4, 1'b1);
        bit_in(1'b1); bit_in(1'b0);
        load(8'hFF, 0, 1'b0);
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL badcfg_len0 got=%b exp=1", cfg_err); end
        idle();
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL badcfg_pulse0 got=%b exp=0", cfg_err); end
        load(8'hFF, ML + 1, 1'b0);
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL badcfg_lenmax got=%b exp=1", cfg_err); end
        bit_in(1'b1);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL badcfg_pulse1 got=%b exp=0", cfg_err); end
        bit_in(1'b1);
        checks++; if (detect_out !== 1'b1 || e_det !== 1'b1) begin failures++; $display("FAIL badcfg_keep got=%b exp=1", detect_out); end
        // Overlapping detection is still active: 1011 + 011 gives a second hit.
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        checks++; if (detect_out !== e_det) begin failures++; $display("FAIL badcfg_ovl got=%b exp=%b", detect_out, e_det); end
    endtask

    task automatic test_saturate();
        load(8'b1, 1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            bit_in(1'b1);
            checks++;
            if (match_count !== CW'(e_cnt)) begin failures++; $display("FAIL sat_cnt step%0d got=%0d exp=%0d", i, match_count, e_cnt); end
        end
        checks++; if (match_count !== CW'(CMAX)) begin failures++; $display("FAIL sat_hold got=%0d exp=%0d", match_count, CMAX); end
    endtask

    task automatic test_clr_with_match();
        cycle(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
        checks++; if (match_count !== CW'(1)) begin failures++; $display("FAIL clrmatch_cnt got=%0d exp=1", match_count); end
        cycle(1'b1, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
        checks++; if (match_count !== '0) begin failures++; $display("FAIL clr_nomatch got=%0d exp=0", match_count); end
    endtask

    task automatic test_reset_mid();
        bit bits[7] = '{1, 0, 1, 1, 1, 0, 1};
        apply_reset();
        foreach (bits[i]) bit_in(bits[i]);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (match_count !== '0 || detect_out !== 1'b0) begin failures++; $display("FAIL midrst_async cnt=%0d det=%b exp=0,0", match_count, detect_out); end
        @(negedge clk);
        reset_n = 1'b1;
        bit_in(1'b1);
        checks++; if (detect_out !== 1'b0) begin failures++; $display("FAIL midrst_stale got=%b exp=0", detect_out); end
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        checks++; if (detect_out !== 1'b1 || e_det !== 1'b1) begin failures++; $display("FAIL midrst_full got=%b exp=1", detect_out); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                load(ML'($urandom), int'($urandom_range(0, ML + 1)), 1'($urandom_range(0, 1)));
            end else begin
                cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b0, '0, 0, 1'b0,
                      $urandom_range(0, 29) == 0);
            end
            checks++;
            if (detect_out !== e_det || match_count !== CW'(e_cnt) || cfg_err !== e_err) begin
                failures++;
                $display("FAIL rand step%0d det=%b/%b cnt=%0d/%0d err=%b/%b (got/exp)",
                         n, detect_out, e_det, match_count, e_cnt, cfg_err, e_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_pattern();
        test_nonoverlap();
        test_overlap();
        test_gap();
        test_bad_cfg();
        test_saturate();
        test_clr_with_match();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
